game_sequencer: RTL and testbench

Top-level round scheduler for the whack-a-mole game. It configures and sequences `light_controller`:
- drives its flick timing (`time_on`, `time_between`), `start`, `load_seed` and reset;
- scores player key hits against lit positions;
- counts missed flicks and advances difficulty levels.

It sits between the board I/O (keys, go button, score display) and `light_controller`.

---
 rtl/wam_pkg.sv | 25 ++
 rtl/game_sequencer_if.sv | 33 +++
 rtl/game_sequencer_hit_tracker.sv | 71 +++++++
 rtl/game_sequencer.sv | 129 ++++++++++++
 tb/tb_game_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole blocks: bus widths, the
// sequencer state encoding and a small saturating-counter helper.
package wam_pkg;

    localparam int LIGHT_W = 9;
    localparam int TIME_W  = 28;
    localparam int SCORE_W = 8;
    localparam int MISS_W  = 4;
    localparam int LEVEL_W = 2;
    localparam int COUNT_W = 6;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_PLAY  = 3'd2,
        SEQ_LEVEL = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_e;

    // Score counter sticks at its maximum instead of wrapping to zero.
    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] value);
        return (value == '1) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Board-side and light_controller-side signals of the round sequencer.
// The sequencer itself uses the slave view; whoever drives keys, go and
// the light_controller feedback uses the master view.
interface game_sequencer_if;
    import wam_pkg::*;

    logic                 go;
    logic [LIGHT_W-1:0]   keys;
    logic [LIGHT_W-1:0]   lights;
    logic [COUNT_W-1:0]   light_counter;
    logic [TIME_W-1:0]    time_on;
    logic [TIME_W-1:0]    time_between;
    logic                 start;
    logic                 load_seed;
    logic                 lc_reset;
    logic [SCORE_W-1:0]   score;
    logic [MISS_W-1:0]    misses;
    logic [LEVEL_W-1:0]   level;
    logic                 game_over;

    modport master (
        output go, keys, lights, light_counter,
        input  time_on, time_between, start, load_seed, lc_reset,
               score, misses, level, game_over
    );

    modport slave (
        input  go, keys, lights, light_counter,
        output time_on, time_between, start, load_seed, lc_reset,
               score, misses, level, game_over
    );

endinterface

// File: rtl/game_sequencer_hit_tracker.sv
// Per-flick hit bookkeeping: remembers the previous light pattern to spot
// the end of a flick, allows at most one scored hit per flick, and counts
// flicks that ended without a hit.
module hit_tracker
    import wam_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LIGHT_W-1:0]   keys_i,
    input  logic [LIGHT_W-1:0]   lights_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 newGame_i,
    output logic [SCORE_W-1:0]   score_o,
    output logic [MISS_W-1:0]    misses_o,
    output logic [MISS_W-1:0]    missesNext_o,
    output logic                 flickEnd_o
);

    logic [LIGHT_W-1:0] lights_q, lights_d;
    logic               hitFlag_q, hitFlag_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MISS_W-1:0]  misses_q, misses_d;
    logic               hit;

    assign flickEnd_o   = enable_i && (lights_q != '0) && (lights_i == '0);
    assign hit          = enable_i && ((keys_i & lights_i) != '0) && !hitFlag_q;
    assign missesNext_o = (flickEnd_o && !hitFlag_q) ? misses_q + 4'd1 : misses_q;
    assign score_o      = score_q;
    assign misses_o     = misses_q;

    // Next-state for the flick tracker, score and miss counters.
    always_comb begin
        lights_d  = lights_q;
        hitFlag_d = hitFlag_q;
        score_d   = score_q;
        misses_d  = missesNext_o;
        if (newGame_i) begin
            score_d  = '0;
            misses_d = '0;
        end
        if (clear_i) begin
            lights_d  = '0;
            hitFlag_d = 1'b0;
        end else if (enable_i) begin
            lights_d = lights_i;
            if (flickEnd_o) begin
                hitFlag_d = 1'b0;
            end else if (hit) begin
                hitFlag_d = 1'b1;
                score_d   = satInc(score_q);
            end
        end
    end

    // Tracker registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lights_q  <= '0;
            hitFlag_q <= 1'b0;
            score_q   <= '0;
            misses_q  <= '0;
        end else begin
            lights_q  <= lights_d;
            hitFlag_q <= hitFlag_d;
            score_q   <= score_d;
            misses_q  <= misses_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Round scheduler for the whack-a-mole game. Starts a game on go, drives
// light_controller through seed load and play phases, and moves through
// the difficulty levels until the last level or too many misses.
module game_sequencer
    import wam_pkg::*;
#(
    parameter int               FLICKS_PER_LEVEL = 10,
    parameter int               NUM_LEVELS       = 4,
    parameter int               MAX_MISSES       = 5,
    parameter logic [TIME_W-1:0] BASE_ON         = 28'd50_000_000,
    parameter logic [TIME_W-1:0] BASE_BTWN       = 28'd25_000_000
)
(
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.slave  bus
);

    localparam logic [LEVEL_W-1:0] LAST_LEVEL   = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [COUNT_W-1:0] FLICK_TARGET = COUNT_W'(FLICKS_PER_LEVEL);
    localparam logic [MISS_W-1:0]  MISS_LIMIT   = MISS_W'(MAX_MISSES);

    seq_state_e         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               start_q, start_d;
    logic               loadSeed_q, loadSeed_d;
    logic               lcReset_q, lcReset_d;
    logic               gameOver_q, gameOver_d;
    logic               newGame;
    logic               flickEnd;
    logic [MISS_W-1:0]  missesNext;

    hit_tracker u_hitTracker (
        .clk          (clk),
        .reset        (reset),
        .keys_i       (bus.keys),
        .lights_i     (bus.lights),
        .enable_i     (state_q == SEQ_PLAY),
        .clear_i      (state_q == SEQ_LOAD),
        .newGame_i    (newGame),
        .score_o      (bus.score),
        .misses_o     (bus.misses),
        .missesNext_o (missesNext),
        .flickEnd_o   (flickEnd)
    );

    // Flick timing halves with every level; level only changes in LEVEL,
    // so these stay steady through LOAD and PLAY.
    assign bus.time_on      = BASE_ON >> level_q;
    assign bus.time_between = BASE_BTWN >> level_q;
    assign bus.start        = start_q;
    assign bus.load_seed    = loadSeed_q;
    assign bus.lc_reset     = lcReset_q;
    assign bus.game_over    = gameOver_q;
    assign bus.level        = level_q;

    // Next state and level; a miss-out takes priority over finishing a level.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        newGame = 1'b0;
        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (bus.go) begin
                    state_d = SEQ_LOAD;
                    level_d = '0;
                    newGame = 1'b1;
                end
            end
            SEQ_LOAD: state_d = SEQ_PLAY;
            SEQ_PLAY: begin
                if (flickEnd) begin
                    if (missesNext == MISS_LIMIT) begin
                        state_d = SEQ_DONE;
                    end else if (bus.light_counter == FLICK_TARGET) begin
                        state_d = SEQ_LEVEL;
                    end
                end
            end
            SEQ_LEVEL: begin
                if (level_q == LAST_LEVEL) begin
                    state_d = SEQ_DONE;
                end else begin
                    level_d = level_q + 2'd1;
                    state_d = SEQ_LOAD;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        start_d    = 1'b0;
        loadSeed_d = 1'b0;
        lcReset_d  = 1'b0;
        gameOver_d = 1'b0;
        case (state_d)
            SEQ_LOAD:  loadSeed_d = 1'b1;
            SEQ_PLAY: begin
                start_d   = 1'b1;
                lcReset_d = 1'b1;
            end
            SEQ_LEVEL: lcReset_d = 1'b1;
            SEQ_DONE:  gameOver_d = 1'b1;
            default:   ;
        endcase
    end

    // State, level and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= SEQ_IDLE;
            level_q    <= '0;
            start_q    <= 1'b0;
            loadSeed_q <= 1'b0;
            lcReset_q  <= 1'b0;
            gameOver_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            start_q    <= start_d;
            loadSeed_q <= loadSeed_d;
            lcReset_q  <= lcReset_d;
            gameOver_q <= gameOver_d;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios plus random flicks,
// predicted from the game rules (score, misses, level progression).
module tb_game_sequencer;

    localparam int FLICKS   = 10;
    localparam int LEVELS   = 4;
    localparam int MAXMISS  = 5;

    logic clk;
    logic reset;

    game_sequencer_if bus();

    game_sequencer #(
        .FLICKS_PER_LEVEL (FLICKS),
        .NUM_LEVELS       (LEVELS),
        .MAX_MISSES       (MAXMISS),
        .BASE_ON          (28'd50_000_000),
        .BASE_BTWN        (28'd25_000_000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    int expScore;
    int expMisses;
    int expLevel;
    int flickCount;
    bit expDone;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic go, input logic [8:0] keys,
                                 input logic [8:0] lights, input logic [5:0] counter);
        bus.go            = go;
        bus.keys          = keys;
        bus.lights        = lights;
        bus.light_counter = counter;
    endtask

    function automatic logic [31:0] onTime(input int lvl);
        return 32'(50_000_000 / (1 << lvl));
    endfunction

    function automatic logic [31:0] gapTime(input int lvl);
        return 32'(25_000_000 / (1 << lvl));
    endfunction

    // Pulse go from IDLE/DONE and check the LOAD cycle and first PLAY cycle.
    task automatic startGame();
        applyStimulus(1'b1, '0, '0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("load.load_seed", 32'(bus.load_seed), 32'd1);
        checkOutput("load.lc_reset", 32'(bus.lc_reset), 32'd0);
        checkOutput("load.start", 32'(bus.start), 32'd0);
        checkOutput("load.score", 32'(bus.score), 32'd0);
        checkOutput("load.misses", 32'(bus.misses), 32'd0);
        checkOutput("load.level", 32'(bus.level), 32'd0);
        checkOutput("load.game_over", 32'(bus.game_over), 32'd0);
        tick();
        checkOutput("play.start", 32'(bus.start), 32'd1);
        checkOutput("play.lc_reset", 32'(bus.lc_reset), 32'd1);
        checkOutput("play.load_seed", 32'(bus.load_seed), 32'd0);
        checkOutput("play.time_on", 32'(bus.time_on), onTime(0));
        checkOutput("play.time_between", 32'(bus.time_between), gapTime(0));
        expScore   = 0;
        expMisses  = 0;
        expLevel   = 0;
        flickCount = 0;
        expDone    = 0;
    endtask

    // What the game rules say happens on the edge after a flick ends.
    task automatic checkFlickOutcome(input bit gotHit);
        if (!gotHit) expMisses++;
        checkOutput("flick.misses", 32'(bus.misses), 32'(expMisses));
        checkOutput("flick.score", 32'(bus.score), 32'(expScore));
        if (expMisses == MAXMISS) begin
            expDone = 1;
            checkOutput("missout.game_over", 32'(bus.game_over), 32'd1);
            checkOutput("missout.start", 32'(bus.start), 32'd0);
            checkOutput("missout.lc_reset", 32'(bus.lc_reset), 32'd0);
            checkOutput("missout.level", 32'(bus.level), 32'(expLevel));
        end else if (flickCount == FLICKS) begin
            checkOutput("level.start", 32'(bus.start), 32'd0);
            checkOutput("level.game_over", 32'(bus.game_over), 32'd0);
            tick();
            if (expLevel == LEVELS - 1) begin
                expDone = 1;
                checkOutput("final.game_over", 32'(bus.game_over), 32'd1);
                checkOutput("final.start", 32'(bus.start), 32'd0);
                checkOutput("final.level", 32'(bus.level), 32'(expLevel));
            end else begin
                expLevel++;
                flickCount = 0;
                applyStimulus(1'b0, '0, '0, '0);
                checkOutput("next.load_seed", 32'(bus.load_seed), 32'd1);
                checkOutput("next.start", 32'(bus.start), 32'd0);
                checkOutput("next.level", 32'(bus.level), 32'(expLevel));
                checkOutput("next.time_on", 32'(bus.time_on), onTime(expLevel));
                checkOutput("next.time_between", 32'(bus.time_between), gapTime(expLevel));
                tick();
                checkOutput("next.play_start", 32'(bus.start), 32'd1);
            end
        end else begin
            checkOutput("flick.still_play", 32'(bus.start), 32'd1);
        end
    endtask

    // One random flick. mode 0: random hit/miss, 1: forced hit, 2: forced miss.
    task automatic doFlick(input int mode);
        logic [8:0] lit;
        logic [8:0] k;
        int onLen;
        bit wantHit;
        bit gotHit;
        lit     = 9'($urandom_range(1, 511));
        onLen   = int'($urandom_range(1, 4));
        wantHit = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        gotHit  = 0;
        flickCount++;
        for (int c = 0; c < onLen; c++) begin
            k = 9'($urandom) & ~lit;
            if (wantHit && (c == onLen - 1 || $urandom_range(0, 1) == 1)) begin
                k = k | (lit & 9'($urandom));
                if ((k & lit) == '0) k = k | lit;
                gotHit = 1;
            end
            applyStimulus(1'b0, k, lit, 6'(flickCount));
            tick();
        end
        if (gotHit && expScore < 255) expScore++;
        applyStimulus(1'b0, '0, lit, 6'(flickCount));
        checkOutput("flick.score_on", 32'(bus.score), 32'(expScore));
        applyStimulus(1'b0, 9'($urandom), '0, 6'(flickCount));
        tick();
        applyStimulus(1'b0, '0, '0, 6'(flickCount));
        checkFlickOutcome(gotHit);
        if (!expDone) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        repeat (3) tick();
        checkOutput("reset.start", 32'(bus.start), 32'd0);
        checkOutput("reset.load_seed", 32'(bus.load_seed), 32'd0);
        checkOutput("reset.lc_reset", 32'(bus.lc_reset), 32'd0);
        checkOutput("reset.game_over", 32'(bus.game_over), 32'd0);
        checkOutput("reset.score", 32'(bus.score), 32'd0);
        checkOutput("reset.misses", 32'(bus.misses), 32'd0);
        checkOutput("reset.level", 32'(bus.level), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("idle.start", 32'(bus.start), 32'd0);

        // Game 1: directed hit flick, wrong-key flick, then miss out.
        $display("[TB] game 1: directed hits and misses");
        startGame();
        flickCount = 1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, (c % 2 == 0) ? 9'b000010000 : 9'b0, 9'b000010000, 6'd1);
            tick();
        end
        expScore = 1;
        applyStimulus(1'b0, '0, '0, 6'd1);
        tick();
        checkFlickOutcome(1'b1);
        flickCount = 2;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 9'b000000001, 9'b000010000, 6'd2);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 6'd2);
        tick();
        checkFlickOutcome(1'b0);
        for (int f = 0; f < 10 && !expDone; f++) doFlick(2);
        checkOutput("game1.game_over", 32'(bus.game_over), 32'd1);
        checkOutput("game1.score", 32'(bus.score), 32'd1);

        // Game 2: every flick hit through all levels.
        $display("[TB] game 2: all hits");
        startGame();
        for (int f = 0; f < 100 && !expDone; f++) doFlick(1);
        checkOutput("game2.game_over", 32'(bus.game_over), 32'd1);
        checkOutput("game2.score", 32'(bus.score), 32'd40);
        checkOutput("game2.level", 32'(bus.level), 32'd3);
        tick();
        checkOutput("game2.held_score", 32'(bus.score), 32'd40);

        // Game 3: random mix of hits and misses.
        $display("[TB] game 3: random flicks");
        startGame();
        for (int f = 0; f < 100 && !expDone; f++) doFlick(0);
        checkOutput("game3.game_over", 32'(bus.game_over), 32'd1);

        // Game 4: go ignored during play, then reset mid-game.
        $display("[TB] game 4: reset mid-play");
        startGame();
        applyStimulus(1'b1, '0, '0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("go_in_play.start", 32'(bus.start), 32'd1);
        checkOutput("go_in_play.load_seed", 32'(bus.load_seed), 32'd0);
        for (int f = 0; f < 7; f++) doFlick(1);
        checkOutput("game4.score", 32'(bus.score), 32'd7);
        reset = 1'b0;
        tick();
        checkOutput("midreset.score", 32'(bus.score), 32'd0);
        checkOutput("midreset.start", 32'(bus.start), 32'd0);
        checkOutput("midreset.lc_reset", 32'(bus.lc_reset), 32'd0);
        checkOutput("midreset.game_over", 32'(bus.game_over), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("idle_after.lc_reset", 32'(bus.lc_reset), 32'd0);
        checkOutput("idle_after.load_seed", 32'(bus.load_seed), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
